narnet_sample_feeder: RTL and testbench

//  Front/back-end stage wrapped around the NARNet core. Accepts raw signed Q8.8 samples on a

---
 rtl/narnet_pkg.sv | 32 +++
 rtl/narnet_sample_feeder_if.sv | 52 +++++
 rtl/narnet_pred_fifo.sv | 70 +++++++
 rtl/narnet_sample_feeder.sv | 144 ++++++++++++++
 tb/tb_narnet_sample_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/narnet_pkg.sv
// Shared types and helpers for the NARNet sample feeder: S8.6 limits,
// the saturating conversion to S8.6 and the feeder FSM state encoding.
package narnet_pkg;

    // Representable range of an S8.6 value held in 8 bits.
    localparam int S8_6_MAX = 127;
    localparam int S8_6_MIN = -128;

    // Width of one prediction FIFO entry: {last, data}.
    localparam int PRED_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_Y = 2'd2,
        ST_PUSH   = 2'd3
    } feeder_state_e;

    // Clamp a signed integer into the S8.6 range and return its 8-bit pattern.
    function automatic logic [7:0] sat_s8_6(input int v);
        logic [7:0] r;
        if (v > S8_6_MAX) begin
            r = 8'h7F;
        end else if (v < S8_6_MIN) begin
            r = 8'h80;
        end else begin
            r = 8'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/narnet_sample_feeder_if.sv
// Bundle of the feeder's stream, core and consumer signals.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds data stable while valid is high and ready
// is low. s_* is the raw-sample input stream, m_* the prediction output
// stream; net_x_ready / net_out_ready are strobes to and from the core.
// slave is the feeder's view, master the view of its surroundings.
interface narnet_sample_feeder_if #(
    parameter int IN_W = 16
);
    import narnet_pkg::*;

    logic            s_valid;
    logic            s_ready;
    logic [IN_W-1:0] s_data;
    logic            mode_closed;
    logic [3:0]      horizon;

    logic            net_enable;
    logic [7:0]      net_x;
    logic            net_x_ready;
    logic [7:0]      net_y;
    logic            net_out_ready;

    logic            m_valid;
    logic            m_ready;
    logic [7:0]      m_data;
    logic            m_last;

    logic            err_timeout;
    feeder_state_e   dbg_state;

    modport slave (
        input  s_valid, s_data, mode_closed, horizon,
        input  net_y, net_out_ready,
        input  m_ready,
        output s_ready,
        output net_enable, net_x, net_x_ready,
        output m_valid, m_data, m_last,
        output err_timeout, dbg_state
    );

    modport master (
        output s_valid, s_data, mode_closed, horizon,
        output net_y, net_out_ready,
        output m_ready,
        input  s_ready,
        input  net_enable, net_x, net_x_ready,
        input  m_valid, m_data, m_last,
        input  err_timeout, dbg_state
    );

endinterface

// File: rtl/narnet_pred_fifo.sv
// Prediction FIFO, first-word fall-through. DEPTH must be a power of two so
// the pointers wrap by plain overflow. A write is taken when not full, or
// when full together with a same-cycle read. Reads of an empty FIFO are
// ignored and the read data is forced to zero while empty.
module narnet_pred_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/narnet_sample_feeder.sv
// Feeder stage around the NARNet core. Quantises raw Q8.8 samples to S8.6,
// issues them to the core with a one-cycle strobe, captures each result on
// the rising edge of the core's result strobe and queues it for the consumer.
// In closed-loop mode each result is re-issued as the next input for up to
// 'horizon' steps. A watchdog drops a sequence whose result never arrives.
module narnet_sample_feeder
    import narnet_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    narnet_sample_feeder_if.slave feed_io
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    feeder_state_e   state_q, state_d;
    logic            live_q;
    logic [7:0]      net_x_q, net_x_d;
    logic [7:0]      y_q, y_d;
    logic [3:0]      steps_q, steps_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
    logic            out_rdy_q;

    logic signed [IN_W:0] q_sum;
    logic [7:0]           q_sat;
    logic                 y_edge;
    logic                 s_ready_w;
    logic                 fifo_wr, fifo_rd, fifo_can_wr;
    logic                 fifo_full, fifo_empty;
    logic [PRED_W-1:0]    fifo_rd_data;

    // Round half up by adding 2 before the arithmetic shift, then clamp.
    // One extra bit of headroom keeps the +2 from wrapping at 0x7FFF.
    assign q_sum = {feed_io.s_data[IN_W-1], feed_io.s_data} + (IN_W+1)'(2);
    assign q_sat = sat_s8_6(int'(q_sum) >>> 2);

    // Result strobe may stay high for several cycles; only its rising edge counts.
    assign y_edge = feed_io.net_out_ready && !out_rdy_q;

    // live_q holds s_ready low for the first cycle after reset.
    assign s_ready_w   = live_q && (state_q == ST_IDLE);
    assign fifo_rd     = feed_io.m_ready && !fifo_empty;
    assign fifo_can_wr = !fifo_full || fifo_rd;

    // FSM next-state, datapath next-state and FIFO write strobe.
    always_comb begin
        state_d = state_q;
        net_x_d = net_x_q;
        y_d     = y_q;
        steps_d = steps_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        fifo_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (feed_io.s_valid && s_ready_w) begin
                    net_x_d = q_sat;
                    steps_d = (feed_io.mode_closed && (feed_io.horizon != 4'd0))
                              ? feed_io.horizon : 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT_Y;
            end
            ST_WAIT_Y: begin
                wdog_d = wdog_q + 1'b1;
                if (y_edge) begin
                    y_d     = feed_io.net_y;
                    state_d = ST_PUSH;
                end else if (wdog_d == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (fifo_can_wr) begin
                    fifo_wr = 1'b1;
                    steps_d = steps_q - 1'b1;
                    if (steps_q > 4'd1) begin
                        net_x_d = y_q;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            live_q    <= 1'b0;
            net_x_q   <= '0;
            y_q       <= '0;
            steps_q   <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            out_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            net_x_q   <= net_x_d;
            y_q       <= y_d;
            steps_q   <= steps_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            out_rdy_q <= feed_io.net_out_ready;
        end
    end

    narnet_pred_fifo #(
        .W     (PRED_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({(steps_q == 4'd1), y_q}),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign feed_io.s_ready     = s_ready_w;
    assign feed_io.net_enable  = live_q;
    assign feed_io.net_x       = net_x_q;
    assign feed_io.net_x_ready = (state_q == ST_ISSUE);
    assign feed_io.m_valid     = !fifo_empty;
    assign feed_io.m_data      = fifo_rd_data[7:0];
    assign feed_io.m_last      = fifo_rd_data[8];
    assign feed_io.err_timeout = err_q;
    assign feed_io.dbg_state   = state_q;

endmodule

// File: tb/tb_narnet_sample_feeder.sv
// Directed bench for narnet_sample_feeder: quantiser table, open/closed loop
// sequences, FIFO backpressure, watchdog timeout and mid-sequence reset.
module tb_narnet_sample_feeder;
    import narnet_pkg::*;

    localparam int TIMEOUT = 255;
    localparam int LIMIT   = 3000;

    logic clk;
    logic rst;

    narnet_sample_feeder_if #(.IN_W(16)) bus ();

    narnet_sample_feeder #(
        .IN_W       (16),
        .FIFO_DEPTH (8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .feed_io (bus)
    );

    int errors = 0;
    int checks = 0;

    // Core model configuration.
    bit         mdl_on;
    bit         mdl_use_const;
    logic [7:0] mdl_const;
    logic [7:0] mdl_add;
    int         mdl_delay;
    int         mdl_hold;

    logic [7:0] issued_q[$];
    logic [8:0] exp_q[$];

    typedef struct {
        logic [15:0] s_data;
        logic [7:0]  exp_x;
    } qvec_t;

    qvec_t qv[12];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "global timeout");
    end

    // Core model: on each issue strobe, answer after mdl_delay cycles and
    // hold the result strobe for mdl_hold cycles.
    initial begin : core_model
        logic [7:0] x;
        bus.net_y         = 8'h00;
        bus.net_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.net_x_ready && mdl_on) begin
                x = bus.net_x;
                repeat (mdl_delay) @(negedge clk);
                bus.net_y         = mdl_use_const ? mdl_const : 8'(x + mdl_add);
                bus.net_out_ready = 1'b1;
                repeat (mdl_hold) @(negedge clk);
                bus.net_out_ready = 1'b0;
            end
        end
    end

    // Record every value issued to the core.
    always @(negedge clk) begin
        if (bus.net_x_ready) begin
            issued_q.push_back(bus.net_x);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        checks++;
        errors++;
        $display("FAIL %s: waited %0d cycles, required within %0d", name, waited, LIMIT);
    endtask

    // Offer one raw sample; returns on the negedge where the issue strobe is expected.
    task automatic send(input logic [15:0] d, input logic closed, input logic [3:0] hor,
                        input logic [7:0] exp_x, input string name);
        int n = 0;
        while (!bus.s_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) bound_fail({name, "_s_ready"}, n);
        bus.s_valid     = 1'b1;
        bus.s_data      = d;
        bus.mode_closed = closed;
        bus.horizon     = hor;
        @(negedge clk);
        bus.s_valid     = 1'b0;
        // Changing the mode inputs after accept must not affect this sequence.
        bus.mode_closed = ~closed;
        bus.horizon     = 4'($urandom_range(15, 0));
        check({name, "_x_ready"}, bus.net_x_ready, 1'b1);
        check({name, "_net_x"}, bus.net_x, exp_x);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(bus.s_ready && bus.dbg_state == ST_IDLE) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) bound_fail({name, "_idle"}, n);
    endtask

    task automatic pop_check(input logic [8:0] exp, input string name);
        check({name, "_m_valid"}, bus.m_valid, 1'b1);
        check({name, "_entry"}, {bus.m_last, bus.m_data}, exp);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
    endtask

    // Pop everything in exp_q, waiting for each entry to appear.
    task automatic drain(input string name);
        int n;
        while (exp_q.size() > 0) begin
            n = 0;
            while (!bus.m_valid && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            if (!bus.m_valid) begin
                bound_fail({name, "_m_valid"}, n);
                exp_q.delete();
            end else begin
                pop_check(exp_q.pop_front(), name);
            end
        end
        check({name, "_empty"}, bus.m_valid, 1'b0);
    endtask

    initial begin
        int n;

        qv[0]  = '{16'h0180, 8'h60};
        qv[1]  = '{16'h7FFF, 8'h7F};
        qv[2]  = '{16'h8000, 8'h80};
        qv[3]  = '{16'h0002, 8'h01};
        qv[4]  = '{16'h0001, 8'h00};
        qv[5]  = '{16'hFFFE, 8'h00};
        qv[6]  = '{16'hFFFD, 8'hFF};
        qv[7]  = '{16'h01FD, 8'h7F};
        qv[8]  = '{16'h01FE, 8'h7F};
        qv[9]  = '{16'h01F9, 8'h7E};
        qv[10] = '{16'hFE00, 8'h80};
        qv[11] = '{16'hE000, 8'h80};

        mdl_on        = 1'b1;
        mdl_use_const = 1'b0;
        mdl_const     = 8'h00;
        mdl_add       = 8'h00;
        mdl_delay     = 3;
        mdl_hold      = 1;

        rst             = 1'b1;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.mode_closed = 1'b0;
        bus.horizon     = 4'd0;
        bus.m_ready     = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_net_x", bus.net_x, 8'h00);
        check("rst_x_ready", bus.net_x_ready, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_last", bus.m_last, 1'b0);
        check("rst_err", bus.err_timeout, 1'b0);
        check("rst_enable", bus.net_enable, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", bus.s_ready, 1'b1);
        check("post_rst_enable", bus.net_enable, 1'b1);

        // Quantiser table, open loop (horizon ignored), core echoes its input.
        for (int i = 0; i < 12; i++) begin
            send(qv[i].s_data, 1'b0, 4'd7, qv[i].exp_x, "quant");
            wait_idle("quant");
            pop_check({1'b1, qv[i].exp_x}, "quant_out");
        end
        check("quant_drained", bus.m_valid, 1'b0);

        // Open loop, slow core returning a constant; strobe held several cycles.
        mdl_use_const = 1'b1;
        mdl_const     = 8'h25;
        mdl_delay     = 40;
        mdl_hold      = 3;
        issued_q.delete();
        send(16'h0100, 1'b0, 4'd1, 8'h40, "open");
        n = 0;
        while (bus.dbg_state != ST_PUSH && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("open_issue_to_push", n, 41);
        check("open_push_s_ready", bus.s_ready, 1'b0);
        check("open_push_m_valid", bus.m_valid, 1'b0);
        @(negedge clk);
        check("open_after_s_ready", bus.s_ready, 1'b1);
        check("open_after_m_valid", bus.m_valid, 1'b1);
        pop_check({1'b1, 8'h25}, "open_out");
        check("open_issues", issued_q.size(), 1);

        // Closed loop with horizon 0 behaves as a single step.
        mdl_use_const = 1'b0;
        mdl_add       = 8'h01;
        mdl_delay     = 5;
        mdl_hold      = 1;
        issued_q.delete();
        send(16'h0040, 1'b1, 4'd0, 8'h10, "hor0");
        wait_idle("hor0");
        check("hor0_issues", issued_q.size(), 1);
        pop_check({1'b1, 8'h11}, "hor0_out");

        // Closed loop, horizon 3, y = x + 1.
        issued_q.delete();
        send(16'h0040, 1'b1, 4'd3, 8'h10, "cl3");
        wait_idle("cl3");
        check("cl3_issues", issued_q.size(), 3);
        if (issued_q.size() == 3) begin
            check("cl3_x0", issued_q[0], 8'h10);
            check("cl3_x1", issued_q[1], 8'h11);
            check("cl3_x2", issued_q[2], 8'h12);
        end
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h13});
        drain("cl3_out");

        // Backpressure: horizon 12 into an 8-deep FIFO with no consumer.
        issued_q.delete();
        send(16'h0080, 1'b1, 4'd12, 8'h20, "bp");
        n = 0;
        while (!(issued_q.size() == 9 && bus.dbg_state == ST_PUSH) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) bound_fail("bp_stall", n);
        repeat (5) @(negedge clk);
        check("bp_stalled_state", bus.dbg_state, ST_PUSH);
        check("bp_stalled_issues", issued_q.size(), 9);
        for (int i = 1; i <= 12; i++) begin
            exp_q.push_back({(i == 12), 8'(8'h20 + i)});
        end
        pop_check(exp_q.pop_front(), "bp_first");
        check("bp_pop_push_state", bus.dbg_state, ST_ISSUE);
        check("bp_pop_push_x", bus.net_x, 8'h29);
        drain("bp_out");
        check("bp_issues", issued_q.size(), 12);

        // Watchdog timeout with one entry already queued.
        mdl_add = 8'h00;
        send(16'h0100, 1'b0, 4'd1, 8'h40, "to_pre");
        wait_idle("to_pre");
        mdl_on = 1'b0;
        send(16'h0200, 1'b0, 4'd1, 8'h7F, "to");
        repeat (TIMEOUT) @(negedge clk);
        check("to_err_before", bus.err_timeout, 1'b0);
        check("to_state_before", bus.dbg_state, ST_WAIT_Y);
        @(negedge clk);
        check("to_err_set", bus.err_timeout, 1'b1);
        check("to_state_idle", bus.dbg_state, ST_IDLE);
        pop_check({1'b1, 8'h40}, "to_fifo");
        check("to_nothing_pushed", bus.m_valid, 1'b0);
        mdl_on = 1'b1;
        send(16'h0040, 1'b0, 4'd1, 8'h10, "to_post");
        wait_idle("to_post");
        check("to_err_sticky", bus.err_timeout, 1'b1);
        pop_check({1'b1, 8'h10}, "to_post_out");

        // Reset while waiting on the core with three entries queued.
        mdl_add = 8'h01;
        send(16'h0040, 1'b1, 4'd3, 8'h10, "rs_fill");
        wait_idle("rs_fill");
        mdl_on = 1'b0;
        send(16'h0100, 1'b0, 4'd1, 8'h40, "rs");
        repeat (10) @(negedge clk);
        check("rs_state_wait", bus.dbg_state, ST_WAIT_Y);
        check("rs_queued", bus.m_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_m_valid", bus.m_valid, 1'b0);
        check("rs_s_ready", bus.s_ready, 1'b0);
        check("rs_net_x", bus.net_x, 8'h00);
        check("rs_err", bus.err_timeout, 1'b0);
        check("rs_m_last", bus.m_last, 1'b0);
        check("rs_enable", bus.net_enable, 1'b0);
        @(negedge clk);
        check("rs_s_ready_next", bus.s_ready, 1'b1);
        check("rs_enable_next", bus.net_enable, 1'b1);
        mdl_on = 1'b1;
        send(16'h0180, 1'b0, 4'd1, 8'h60, "rs_post");
        wait_idle("rs_post");
        pop_check({1'b1, 8'h61}, "rs_post_out");
        check("rs_post_empty", bus.m_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
